// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter that shares one 8-to-3 encoder among 8 requesters.
// Grants are held while requested, up to MAX_HOLD cycles, with a one-cycle gap between grants.
module rr_encoder_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic       CP,
    input  logic       CLR,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] idx,
    output logic       valid,
    output logic       expired,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state;
    logic [2:0]        ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic              win_found;
    logic [2:0]        win_idx;
    logic [2:0]        probe;

    // First set request bit at or after ptr, wrapping 7 -> 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        probe     = 3'd0;
        for (int i = 0; i < 8; i++) begin
            probe = ptr + 3'(i);
            if (!win_found && req[probe]) begin
                win_found = 1'b1;
                win_idx   = probe;
            end
        end
    end

    always_ff @(posedge CP or posedge CLR) begin
        if (CLR) begin
            state    <= IDLE;
            grant    <= 8'd0;
            idx      <= 3'd0;
            expired  <= 1'b0;
            ptr      <= 3'd0;
            hold_cnt <= '0;
        end else begin
            expired <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (win_found) begin
                        grant    <= 8'd1 << win_idx;
                        idx      <= win_idx;
                        hold_cnt <= HOLD_W'(1);
                        state    <= GRANT;
                    end else begin
                        grant    <= 8'd0;
                        idx      <= 3'd0;
                        hold_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                GRANT: begin
                    if (req[idx] && (hold_cnt < HOLD_W'(MAX_HOLD))) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end else begin
                        // Release (dropped) or force-release (tenure exhausted); next search starts past idx.
                        expired  <= req[idx];
                        grant    <= 8'd0;
                        idx      <= 3'd0;
                        ptr      <= idx + 3'd1;
                        hold_cnt <= '0;
                        state    <= GAP;
                    end
                end
                default: begin
                    grant    <= 8'd0;
                    idx      <= 3'd0;
                    hold_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign valid     = |grant;
    assign dbg_state = state;

endmodule
